// File: rtl/twiddle64_sched.sv
// ---------------------------------------------------------------------------
// twiddle64_sched
//
// Sequencer for the 64-point radix-8 twiddle stage. It tracks the sample
// position n inside a 64-sample frame and computes the twiddle exponent
// e = n[5:3] * n[2:0] for W64^e. It reduces e to a first-octant constant
// select (0..8) plus mirror and quadrant fix-up controls. Sample data is
// carried alongside the controls with matching latency (2 cycles).
//
// Handshake: din_valid qualifies din_sof/din_real/din_imag on each rising
// edge. There is no backpressure, so every accepted sample reappears with
// dout_valid exactly two cycles later.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   din_valid, din_sof      input sample valid / start of frame
//   din_real, din_imag      signed sample data (passed through unchanged)
//   bypass_wr, bypass_in    write strobe / value for the bypass register
//   dout_valid, dout_sof    output sample valid / first sample of frame
//   dout_real, dout_imag    delayed sample data
//   dout_idx                sample index n within frame
//   tw_sel                  constant multiplier select, 0..8
//   tw_mirror               apply conjugate-mirror fix-up
//   tw_quad                 number of -j rotations after the multiply
//   frame_done              pulse with the index-63 output of a frame
//   sync_err                sticky framing error, cleared only by reset
//   dbg_state               current FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module twiddle64_sched #(
  parameter int DATA_WIDTH     = 14,
  parameter bit BYPASS_DEFAULT = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din_valid,
  input  logic                         din_sof,
  input  logic signed [DATA_WIDTH-1:0] din_real,
  input  logic signed [DATA_WIDTH-1:0] din_imag,
  input  logic                         bypass_wr,
  input  logic                         bypass_in,
  output logic                         dout_valid,
  output logic                         dout_sof,
  output logic signed [DATA_WIDTH-1:0] dout_real,
  output logic signed [DATA_WIDTH-1:0] dout_imag,
  output logic [5:0]                   dout_idx,
  output logic [3:0]                   tw_sel,
  output logic                         tw_mirror,
  output logic [1:0]                   tw_quad,
  output logic                         frame_done,
  output logic                         sync_err,
  output logic                         dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Frame tracking and bypass
  state_t                  r_state;
  logic [5:0]              r_cnt;
  logic                    r_bypass;
  logic                    r_sync_err;

  // Stage 1
  logic                    r1_valid;
  logic                    r1_sof;
  logic [5:0]              r1_n;
  logic [5:0]              r1_e;
  logic [DATA_WIDTH-1:0]   r1_real;
  logic [DATA_WIDTH-1:0]   r1_imag;

  // Stage 2
  logic                    r2_valid;
  logic                    r2_sof;
  logic [DATA_WIDTH-1:0]   r2_real;
  logic [DATA_WIDTH-1:0]   r2_imag;
  logic [5:0]              r2_idx;
  logic [3:0]              r2_sel;
  logic                    r2_mirror;
  logic [1:0]              r2_quad;
  logic                    r2_done;

  logic                    w_accept;
  logic [5:0]              w_n;
  logic [5:0]              w_e;
  logic [3:0]              w_f;
  logic                    w_mirror;
  logic [3:0]              w_sel;

  // A sof always starts a new frame at n=0, even in the middle of one.
  // Outside a frame only a sof sample is accepted.
  assign w_accept = din_valid & (din_sof | (r_state == ST_RUN));
  assign w_n      = din_sof ? 6'd0 : r_cnt;
  // 3x3-bit product, max 7*7=49, always fits in 6 bits.
  assign w_e      = r_bypass ? 6'd0 : ({3'b000, w_n[5:3]} * {3'b000, w_n[2:0]});

  // Octant reduction. For f in 9..15, 16-f equals -f modulo 16, which is
  // what a plain 4-bit negate yields.
  assign w_f      = r1_e[3:0];
  assign w_mirror = (w_f > 4'd8);
  assign w_sel    = w_mirror ? (4'd0 - w_f) : w_f;

  // FSM, frame counter, bypass register, sync error and stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 6'd0;
      r_bypass   <= BYPASS_DEFAULT;
      r_sync_err <= 1'b0;
      r1_valid   <= 1'b0;
      r1_sof     <= 1'b0;
      r1_n       <= 6'd0;
      r1_e       <= 6'd0;
      r1_real    <= '0;
      r1_imag    <= '0;
    end else begin
      // Sample accepted in this same cycle still sees the old bypass value.
      if (bypass_wr) r_bypass <= bypass_in;

      if (din_valid) begin
        if (din_sof) begin
          if (r_state == ST_RUN) r_sync_err <= 1'b1;  // aborted frame
          r_state <= ST_RUN;
          r_cnt   <= 6'd1;
        end else if (r_state == ST_IDLE) begin
          r_sync_err <= 1'b1;                         // dropped stray sample
        end else if (r_cnt == 6'd63) begin
          r_state <= ST_IDLE;
          r_cnt   <= 6'd0;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end

      r1_valid <= w_accept;
      if (w_accept) begin
        r1_sof  <= din_sof;
        r1_n    <= w_n;
        r1_e    <= w_e;
        r1_real <= din_real;
        r1_imag <= din_imag;
      end
    end
  end

  // Stage 2: reduction outputs and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_sof    <= 1'b0;
      r2_real   <= '0;
      r2_imag   <= '0;
      r2_idx    <= 6'd0;
      r2_sel    <= 4'd0;
      r2_mirror <= 1'b0;
      r2_quad   <= 2'd0;
      r2_done   <= 1'b0;
    end else begin
      r2_valid <= r1_valid;
      r2_sof   <= r1_valid & r1_sof;
      // An aborted frame never reaches n=63, so index 63 marks completion.
      r2_done  <= r1_valid & (r1_n == 6'd63);
      if (r1_valid) begin
        r2_real   <= r1_real;
        r2_imag   <= r1_imag;
        r2_idx    <= r1_n;
        r2_sel    <= w_sel;
        r2_mirror <= w_mirror;
        r2_quad   <= r1_e[5:4];
      end
    end
  end

  assign dout_valid = r2_valid;
  assign dout_sof   = r2_sof;
  assign dout_real  = r2_real;
  assign dout_imag  = r2_imag;
  assign dout_idx   = r2_idx;
  assign tw_sel     = r2_sel;
  assign tw_mirror  = r2_mirror;
  assign tw_quad    = r2_quad;
  assign frame_done = r2_done;
  assign sync_err   = r_sync_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_twiddle64_sched.sv
// ---------------------------------------------------------------------------
// tb_twiddle64_sched
//
// Bench for twiddle64_sched. The driver updates a frame-position model and
// pushes the expected output of every accepted sample onto exp_q, together
// with the cycle it is due. An independent monitor pops and compares on each
// dout_valid. The twiddle controls are derived arithmetically from
// e = (n/8)*(n%8).
// ---------------------------------------------------------------------------
module tb_twiddle64_sched;
  localparam int DW = 14;
  localparam int W  = 1 + DW + DW + 6 + 4 + 1 + 2 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 din_valid, din_sof, bypass_wr, bypass_in;
  logic signed [DW-1:0] din_real, din_imag;
  logic                 dout_valid, dout_sof, tw_mirror, frame_done, sync_err, dbg_state;
  logic signed [DW-1:0] dout_real, dout_imag;
  logic [5:0]           dout_idx;
  logic [3:0]           tw_sel;
  logic [1:0]           tw_quad;

  twiddle64_sched #(.DATA_WIDTH(DW), .BYPASS_DEFAULT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_sof(din_sof),
    .din_real(din_real), .din_imag(din_imag),
    .bypass_wr(bypass_wr), .bypass_in(bypass_in),
    .dout_valid(dout_valid), .dout_sof(dout_sof),
    .dout_real(dout_real), .dout_imag(dout_imag),
    .dout_idx(dout_idx), .tw_sel(tw_sel), .tw_mirror(tw_mirror),
    .tw_quad(tw_quad), .frame_done(frame_done), .sync_err(sync_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int           due_q[$];

  // Reference model: position of next sample (-1 = waiting for sof).
  int m_pos    = -1;
  bit m_bypass = 1'b0;
  bit m_err    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic s, input logic [DW-1:0] re,
      input logic [DW-1:0] im, input logic [5:0] idx, input logic [3:0] sel,
      input logic mir, input logic [1:0] quad, input logic done);
    return {s, re, im, idx, sel, mir, quad, done};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit s, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input bit bw, input bit bi);
    int n, e, f;
    logic [5:0] n6;
    logic [3:0] sel;
    logic [1:0] quad;
    @(negedge clk);
    din_valid = v; din_sof = s; din_real = re; din_imag = im;
    bypass_wr = bw; bypass_in = bi;
    if (v) begin
      n = -1;
      if (s) begin
        if (m_pos != -1) m_err = 1'b1;
        n = 0;
        m_pos = 1;
      end else if (m_pos == -1) begin
        m_err = 1'b1;
      end else begin
        n = m_pos;
        m_pos = (m_pos == 63) ? -1 : m_pos + 1;
      end
      if (n >= 0) begin
        e    = m_bypass ? 0 : (n / 8) * (n % 8);
        f    = e % 16;
        n6   = 6'(n);
        sel  = 4'((f <= 8) ? f : 16 - f);
        quad = 2'(e / 16);
        exp_q.push_back(pack(s, re, im, n6, sel, f > 8, quad, n == 63));
        due_q.push_back(cyc + 2);
      end
    end
    if (bw) m_bypass = bi;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, '0, '0, 0, 0);
  endtask

  // gap cycles after each sample chosen in [gmin,gmax]
  task automatic send_frame(input int gmin, input int gmax, input bit rnd_data);
    logic [DW-1:0] re, im;
    for (int n = 0; n < 64; n++) begin
      re = rnd_data ? DW'($urandom) : DW'(n);
      im = rnd_data ? DW'($urandom) : DW'(63 - n);
      drive(1, n == 0, re, im, 0, 0);
      idle($urandom_range(gmax, gmin));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_fields"}, 64'(pack(dout_sof, dout_real, dout_imag, dout_idx, tw_sel,
                                   tw_mirror, tw_quad, frame_done)), 64'd0);
    chk({tag, "_sync_err"}, 64'(sync_err), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    din_valid = 0; din_sof = 0; bypass_wr = 0;
    exp_q.delete(); due_q.delete();
    m_pos = -1; m_err = 1'b0; m_bypass = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output idx=%0d actual=valid required=none t=%0t", dout_idx, $time);
      end else begin
        logic [W-1:0] e;
        int due;
        e   = exp_q.pop_front();
        due = due_q.pop_front();
        chk("output_fields", 64'(pack(dout_sof, dout_real, dout_imag, dout_idx, tw_sel,
                                      tw_mirror, tw_quad, frame_done)), 64'(e));
        chk("output_latency", 64'(cyc), 64'(due));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    din_valid = 0; din_sof = 0; din_real = '0; din_imag = '0;
    bypass_wr = 0; bypass_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // continuous frame, data = n
    send_frame(0, 0, 0);
    idle(3);
    chk("sync_err_continuous", 64'(sync_err), 64'(m_err));

    // gapped: valid every third cycle
    send_frame(2, 2, 1);
    // random gaps
    send_frame(0, 3, 1);
    idle(3);
    chk("sync_err_gapped", 64'(sync_err), 64'(m_err));

    // sof at n=20 mid-frame
    for (int n = 0; n < 20; n++) drive(1, n == 0, DW'(n), DW'($urandom), 0, 0);
    drive(0, 0, '0, '0, 0, 0);
    chk("sync_err_before_abort", 64'(sync_err), 64'd0);
    drive(1, 1, DW'(20), DW'($urandom), 0, 0);
    drive(1, 0, DW'(21), DW'($urandom), 0, 0);
    chk("sync_err_abort_rise", 64'(sync_err), 64'(m_err));
    for (int n = 2; n < 64; n++) drive(1, 0, DW'($urandom), DW'($urandom), 0, 0);
    idle(3);

    // valid without sof after reset
    do_reset();
    drive(1, 0, DW'(5), DW'(6), 0, 0);
    drive(0, 0, '0, '0, 0, 0);
    chk("sync_err_stray", 64'(sync_err), 64'(m_err));
    idle(3);
    send_frame(0, 1, 1);
    idle(3);

    // bypass whole frame, then clear it
    drive(0, 0, '0, '0, 1, 1);
    send_frame(0, 0, 1);
    drive(0, 0, '0, '0, 1, 0);
    // bypass toggled mid-frame, coincident with an accepted sample
    for (int n = 0; n < 64; n++)
      drive(1, n == 0, DW'($urandom), DW'($urandom), n == 17 || n == 40, n == 17);
    idle(3);

    // reset at n=30
    for (int n = 0; n <= 30; n++) drive(1, n == 0, DW'($urandom), DW'($urandom), 0, 0);
    do_reset();
    for (int k = 0; k < 5; k++) drive(1, 0, DW'($urandom), DW'($urandom), 0, 0);
    idle(3);
    chk("sync_err_after_reset_drop", 64'(sync_err), 64'(m_err));
    send_frame(0, 0, 1);
    idle(3);

    // randomized traffic
    for (int k = 0; k < 1200; k++) begin
      bit v, s, bw;
      v  = ($urandom_range(3, 0) != 0);
      s  = v && ((m_pos == -1) ? ($urandom_range(3, 0) == 0) : ($urandom_range(80, 0) == 0));
      bw = ($urandom_range(60, 0) == 0);
      drive(v, s, DW'($urandom), DW'($urandom), bw, 1'($urandom));
    end

    idle(4);
    chk("sync_err_final", 64'(sync_err), 64'(m_err));
    chk("state_final", 64'(dbg_state), 64'(m_pos != -1));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twiddle64_sched.md
# twiddle64_sched

Sequencer for the 64-point twiddle stage: tracks sample position inside a 64-sample radix-8 frame, computes twiddle exponent W64^e per sample, and reduces it to a first-octant constant select (0..8) plus quadrant/mirror fix-up controls. Sits between the first radix-8 butterfly and the bank of constant twiddle multipliers. Drives the select mux and post-rotation stage, passing the data along with matching latency.

## Interface
Parameters:
- DATA_WIDTH, 14, width of signed real/imag sample.
- BYPASS_DEFAULT, 0, reset value of internal bypass register (1 = force e=0 for every sample).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din_valid  in  1  sample valid.
- din_sof  in  1  start of frame, qualified by din_valid.
- din_real  in  DATA_WIDTH  signed real part.
- din_imag  in  DATA_WIDTH  signed imag part.
- bypass_wr  in  1  write strobe for bypass register.
- bypass_in  in  1  bypass value written on bypass_wr.
- dout_valid  out  1  output sample valid.
- dout_sof  out  1  first sample of frame.
- dout_real  out  DATA_WIDTH  delayed din_real.
- dout_imag  out  DATA_WIDTH  delayed din_imag.
- dout_idx  out  6  sample index n within frame.
- tw_sel  out  4  constant multiplier select, 0..8.
- tw_mirror  out  1  1 = apply conjugate-mirror fix-up.
- tw_quad  out  2  number of -j rotations to apply after multiply.
- frame_done  out  1  one-cycle pulse with index-63 output sample.
- sync_err  out  1  sticky framing error flag.

## Operation
- FSM states IDLE, RUN. Reset → IDLE, cnt=0, bypass=BYPASS_DEFAULT.
- IDLE: din_valid&din_sof → accept as n=0, go RUN, cnt=1. din_valid without sof → sample dropped (no output), sync_err set.
- RUN: each din_valid accepts sample n=cnt, cnt increments. Accepting n=63 → IDLE, cnt=0. din_valid&din_sof in RUN → treated as n=0 of a new frame (cnt=1), sync_err set, no frame_done for the aborted frame.
- Cycles with din_valid=0: state/counter hold; no output.
- Exponent: a=n[5:3], b=n[2:0], e=a*b (6-bit unsigned, max 49, no wrap). bypass=1 → e=0.
- Reduction: q=e[5:4], f=e[3:0]. f≤8 → tw_sel=f, tw_mirror=0; f>8 → tw_sel=16−f, tw_mirror=1. tw_quad=q.
- Bypass register updated on bypass_wr at any time; takes effect from the next accepted sample (frames may mix; no guarding).
- sync_err cleared only by reset.
- Data fields not interpreted; passed unchanged.

## Timing
- Two-stage pipeline, latency exactly 2 cycles from accepted input to dout_valid; one sample/cycle throughput, no backpressure.
- Stage 1 registers n, e, data, sof, valid; stage 2 registers reduction outputs, data, dout_idx, dout_sof, frame_done.
- All outputs registered. Reset values: dout_valid=0, dout_sof=0, dout_real=0, dout_imag=0, dout_idx=0, tw_sel=0, tw_mirror=0, tw_quad=0, frame_done=0, sync_err=0.
- dout_sof=1 exactly on n=0 output; frame_done=1 exactly on n=63 output of a completed frame.
- sync_err rises 1 cycle after the offending input edge (not pipelined).
- Reset asserted mid-frame: pipeline contents discarded, outputs go to reset values immediately (asynchronous); after release, FSM waits in IDLE for sof.

## Test plan
- Continuous frame: sof + 64 back-to-back valids, data=n → dout_valid 2 cycles later for 64 cycles; n=0: sel0/m0/q0; n=27 (a3,b3,e9): sel7/m1/q0; n=52 (a6,b4,e24): sel8/m0/q1; n=63 (e49): sel1/m0/q3, frame_done=1; sync_err=0.
- Gapped input: valid every third cycle over a frame → same per-index controls as continuous case, each output exactly 2 cycles after its input, frame_done on index 63 only.
- Sof at n=20 mid-frame → that sample out with dout_idx=0, dout_sof=1, sync_err=1 next cycle; no frame_done for aborted frame; new frame completes normally.
- Valid without sof after reset → no dout_valid, sync_err=1; following sof frame processed normally.
- bypass_wr=1, bypass_in=1 before frame → all 64 outputs tw_sel=0, tw_mirror=0, tw_quad=0, data unchanged.
- Assert rst_n=0 at n=30 for 1 cycle → all outputs 0 asynchronously; remaining samples without sof dropped, sync_err=1.
